down_timer: RTL and testbench

DOWN_TIMER -- requirements
Module: down_timer

---
 rtl/down_timer_pkg.sv | 17 +
 rtl/down_timer_if.sv | 24 ++
 rtl/down_counter_core.sv | 34 +++
 rtl/down_timer.sv | 77 +++++++
 tb/tb_down_timer.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/down_timer_pkg.sv
// Shared types and constants for the down_timer block.
// Latency: none (declarations only).
// Backpressure: not applicable.
package down_timer_pkg;

    // Default counter / load-value width in bits.
    localparam int DT_WIDTH = 12;

    // Timer control states; busy is asserted in RUN and HOLD.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/down_timer_if.sv
// Control and status bundle between a timer user (master) and down_timer (slave).
// Latency: none (wires only).
// Backpressure: none; Load/Enabled/Reload are sampled every rising edge.
interface down_timer_if import down_timer_pkg::*; #(
    parameter int WIDTH = DT_WIDTH
);
    logic             Load;
    logic             Enabled;
    logic             Reload;
    logic [WIDTH-1:0] Loadvalue;
    logic [WIDTH-1:0] counter;
    logic             done;
    logic             busy;

    modport master (
        output Load, Enabled, Reload, Loadvalue,
        input  counter, done, busy
    );

    modport slave (
        input  Load, Enabled, Reload, Loadvalue,
        output counter, done, busy
    );
endinterface

// File: rtl/down_counter_core.sv
// Count register with load, reload-from-shadow, floored decrement and hold.
// Latency: count updates on the edge after a command; zero is a combinational decode.
// Backpressure: none; exactly one command acts per edge (load > reload > dec > hold).
module down_counter_core #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    input  logic             reload,
    output logic [WIDTH-1:0] count,
    output logic             zero
);
    logic [WIDTH-1:0] reload_val;

    assign zero = (count == '0);

    // Count and reload-shadow registers; decrement is floored at zero so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            reload_val <= '0;
        end else if (load) begin
            count      <= load_value;
            reload_val <= load_value;
        end else if (reload) begin
            count      <= reload_val;
        end else if (dec && !zero) begin
            count      <= count - WIDTH'(1);
        end
    end
endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with pause, auto-reload and a terminal-count pulse.
// Latency: counter/done registered (1 edge after inputs); busy decodes state directly.
// Backpressure: none; inputs sampled every edge, Load overrides everything but reset.
module down_timer import down_timer_pkg::*; #(
    parameter int WIDTH = DT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    down_timer_if.slave  bus
);
    state_t           state;
    logic             done_q;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             at_one;
    logic             running;
    logic             dec;
    logic             rld;

    // Counting only happens in RUN with Enabled and no competing Load.
    assign at_one  = (count == WIDTH'(1));
    assign running = (state == RUN) && bus.Enabled && !bus.Load;
    assign dec     = running && !zero;
    assign rld     = running && zero && bus.Reload;

    down_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .rst        (rst),
        .load       (bus.Load),
        .load_value (bus.Loadvalue),
        .dec        (dec),
        .reload     (rld),
        .count      (count),
        .zero       (zero)
    );

    // Control FSM with registered done: the pulse lands in the cycle the counter shows 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.Load) begin
                state <= (bus.Loadvalue != '0) ? RUN : IDLE;
            end else begin
                case (state)
                    RUN: begin
                        if (!bus.Enabled) begin
                            state <= HOLD;
                        end else if (zero) begin
                            // Only reachable in reload mode; if reload was dropped, park in DONE.
                            state <= bus.Reload ? RUN : DONE;
                        end else if (at_one) begin
                            done_q <= 1'b1;
                            state  <= bus.Reload ? RUN : DONE;
                        end
                    end
                    HOLD: begin
                        // Resume without decrementing on the resume edge.
                        if (bus.Enabled) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                        // IDLE and DONE are left only by Load.
                        state <= state;
                    end
                endcase
            end
        end
    end

    assign bus.counter = count;
    assign bus.done    = done_q;
    assign bus.busy    = (state == RUN) || (state == HOLD);
endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: per-cycle expectations queued at drive time.
// Latency: each step compares 1 ns after the rising edge it targets.
// Backpressure: not applicable.
module tb_down_timer;
    import down_timer_pkg::*;

    localparam int W = DT_WIDTH;

    logic clk = 1'b0;
    logic rst;

    down_timer_if #(.WIDTH(W)) bus();

    down_timer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         done;
        logic         busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue what the next edge must produce, then compare.
    task automatic step(input string tag, input logic ld, input logic en, input logic rl,
                        input logic [W-1:0] lv, input logic [W-1:0] ec,
                        input logic ed, input logic eb);
        exp_t e;
        @(negedge clk);
        bus.Load      = ld;
        bus.Enabled   = en;
        bus.Reload    = rl;
        bus.Loadvalue = lv;
        sb_q.push_back('{cnt: ec, done: ed, busy: eb});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val({tag, ".cnt"},  32'(bus.counter), 32'(e.cnt));
            check_val({tag, ".done"}, 32'(bus.done),    32'(e.done));
            check_val({tag, ".busy"}, 32'(bus.busy),    32'(e.busy));
        end
    endtask

    initial begin
        rst           = 1'b0;
        bus.Load      = 1'b0;
        bus.Enabled   = 1'b0;
        bus.Reload    = 1'b0;
        bus.Loadvalue = '0;
        #12;
        check_val("rst.cnt",  32'(bus.counter), 32'd0);
        check_val("rst.done", 32'(bus.done),    32'd0);
        check_val("rst.busy", 32'(bus.busy),    32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic one-shot from 5.
        step("basic.load", 1, 0, 0, W'(5), W'(5), 0, 1);
        for (int i = 4; i >= 1; i--) step("basic.run", 0, 1, 0, '0, W'(i), 0, 1);
        step("basic.tc", 0, 1, 0, '0, W'(0), 1, 0);
        for (int i = 0; i < 20; i++) step("basic.after", 0, 1, 1'(i % 2), '0, W'(0), 0, 0);

        // Pause and resume from 26.
        step("pause.load", 1, 0, 0, W'(26), W'(26), 0, 1);
        for (int i = 25; i >= 23; i--) step("pause.run", 0, 1, 0, '0, W'(i), 0, 1);
        for (int i = 0; i < 10; i++) step("pause.hold", 0, 0, 0, '0, W'(23), 0, 1);
        step("pause.resume", 0, 1, 0, '0, W'(23), 0, 1);
        for (int i = 22; i >= 20; i--) step("pause.cont", 0, 1, 0, '0, W'(i), 0, 1);

        // Load while running and while held restarts without a done pulse.
        step("reload.run", 1, 1, 0, W'(9), W'(9), 0, 1);
        step("hold.again", 0, 0, 0, '0, W'(9), 0, 1);
        step("reload.hold", 1, 0, 0, W'(2), W'(2), 0, 1);
        step("short.run", 0, 1, 0, '0, W'(1), 0, 1);
        step("short.tc", 0, 1, 0, '0, W'(0), 1, 0);

        // Auto-reload from 3: 3,2,1,0,3,2,1,0,3.
        step("auto.load", 1, 0, 1, W'(3), W'(3), 0, 1);
        for (int i = 0; i < 8; i++) begin
            int v;
            v = 2 - (i % 4);
            if (v < 0) v = 3;
            step("auto.run", 0, 1, 1, '0, W'(v), (v == 0), 1);
        end

        // Load of zero goes straight to IDLE.
        step("zero.load", 1, 1, 1, W'(0), W'(0), 0, 0);
        for (int i = 0; i < 3; i++) step("zero.idle", 0, 1, 1, '0, W'(0), 0, 0);

        // Full-scale count, then no wrap at zero.
        step("max.load", 1, 1, 0, {W{1'b1}}, {W{1'b1}}, 0, 1);
        for (int i = (1 << W) - 2; i >= 0; i--) step("max.run", 0, 1, 0, '0, W'(i), (i == 0), (i != 0));
        for (int i = 0; i < 3; i++) step("max.floor", 0, 1, 0, '0, W'(0), 0, 0);

        // Load coincident with terminal count wins.
        step("coin.load", 1, 0, 0, W'(2), W'(2), 0, 1);
        step("coin.run", 0, 1, 0, '0, W'(1), 0, 1);
        step("coin.tc", 1, 1, 0, W'(7), W'(7), 0, 1);
        step("coin.next", 0, 1, 0, '0, W'(6), 0, 1);

        // Asynchronous reset mid-count from 25.
        step("arst.load", 1, 0, 0, W'(25), W'(25), 0, 1);
        step("arst.run", 0, 1, 0, '0, W'(24), 0, 1);
        step("arst.run", 0, 1, 0, '0, W'(23), 0, 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst.cnt",  32'(bus.counter), 32'd0);
        check_val("arst.done", 32'(bus.done),    32'd0);
        check_val("arst.busy", 32'(bus.busy),    32'd0);
        bus.Load      = 1'b1;
        bus.Loadvalue = W'(9);
        @(posedge clk);
        #1;
        check_val("arst.held", 32'(bus.counter), 32'd0);
        @(negedge clk);
        bus.Load = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < 3; i++) step("arst.after", 0, 1, 0, '0, W'(0), 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
